// File: rtl/sram_sp_pkg.sv
// Shared sizing defaults and word type for the single-port SRAM.
package sram_sp_pkg;

  localparam int unsigned ADDR_W_DEF = 16;
  localparam int unsigned DATA_W_DEF = 32;

  typedef logic [DATA_W_DEF-1:0] word_t;

endpackage : sram_sp_pkg

// File: rtl/sram_array.sv
// Pure storage: synchronous write port, combinational read by address.
module sram_array
  import sram_sp_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_c
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  // Storage is intentionally not reset; contents are undefined until written.
  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  assign rdata_c = mem_q[addr_i];

endmodule : sram_array

// File: rtl/sram_sp.sv
// Single-port synchronous SRAM: enable decode, registered read data, reset handling.
module sram_sp
  import sram_sp_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] ADDR,
  input  logic [DATA_W-1:0] DI,
  input  logic              EN,
  input  logic              WE,
  output logic [DATA_W-1:0] DO
);

  logic              wr_en_c;
  logic              rd_en_c;
  logic [DATA_W-1:0] rdata_c;
  logic [DATA_W-1:0] do_d;
  logic [DATA_W-1:0] do_q;

  // Writes are suppressed while reset is held so no edge under reset lands in storage.
  assign wr_en_c = EN & WE & rst_n;
  assign rd_en_c = EN & ~WE;

  sram_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_array (
    .clk     (clk),
    .we_i    (wr_en_c),
    .addr_i  (ADDR),
    .wdata_i (DI),
    .rdata_c (rdata_c)
  );

  always_comb begin
    do_d = do_q;
    if (rd_en_c) begin
      do_d = rdata_c;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      do_q <= '0;
    end else begin
      do_q <= do_d;
    end
  end

  assign DO = do_q;

endmodule : sram_sp

// File: tb/tb_sram_sp.sv
// Self-checking bench for sram_sp: directed scenarios plus randomized traffic vs. an array model.
module tb_sram_sp;
  import sram_sp_pkg::*;

  localparam int unsigned AW    = 16;
  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 65536;

  logic          clk;
  logic          rst_n;
  logic [AW-1:0] addr;
  logic [DW-1:0] di;
  logic          en;
  logic          we;
  logic [DW-1:0] dout;

  int unsigned errors = 0;
  int unsigned checks = 0;

  // Reference: what memory holds, which words were written, and what DO should show.
  word_t       model [DEPTH];
  bit          wr_ok [DEPTH];
  word_t       exp_do;

  sram_sp #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ADDR  (addr),
    .DI    (di),
    .EN    (en),
    .WE    (we),
    .DO    (dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%08h exp=%08h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    en = 1'b1; we = 1'b1; addr = a; di = d;
    cyc();
    if (rst_n) begin
      model[a] = d;
      wr_ok[a] = 1'b1;
    end
    en = 1'b0; we = 1'b0;
    chk("write_holds_do", dout, exp_do);
  endtask

  task automatic do_read(input string tag, input logic [AW-1:0] a);
    en = 1'b1; we = 1'b0; addr = a;
    cyc();
    exp_do = model[a];
    en = 1'b0;
    chk(tag, dout, exp_do);
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; we = 1'b0; addr = '0; di = '0;
    exp_do = '0;
    #2;
    chk("reset_state", dout, 32'h0);
    cyc(); cyc();
    rst_n = 1'b1;
    cyc();
    chk("after_release", dout, 32'h0);

    // Asynchronous reset clears DO without a clock edge and blocks writes.
    do_write(16'h0100, 32'hDEADBEEF);
    do_read("pre_reset_read", 16'h0100);
    rst_n = 1'b0;
    #2;
    exp_do = '0;
    chk("async_reset_do", dout, 32'h0);
    en = 1'b1; we = 1'b1; addr = 16'h0100; di = 32'h00000BAD;
    cyc();
    chk("reset_hold_do", dout, 32'h0);
    en = 1'b0; we = 1'b0;
    rst_n = 1'b1;
    cyc();
    chk("reset_stays_zero", dout, 32'h0);
    do_read("write_blocked_in_reset", 16'h0100);

    // Sweep (stride 8 keeps runtime modest): write i then read i back-to-back.
    for (int i = 0; i < int'(DEPTH); i += 8) begin
      do_write(AW'(i), DW'(i));
      do_read("sweep", AW'(i));
      chk("sweep_low16", {16'h0, dout[15:0]}, {16'h0, 16'(i)});
    end

    // Write does not disturb DO.
    do_write(16'd5, 32'h5);
    do_read("read5", 16'd5);
    do_write(16'd6, 32'hAAAA5555);
    chk("do_after_write6", dout, 32'h5);
    do_read("read6", 16'd6);

    // EN low blocks the write and holds DO.
    do_write(16'd10, 32'hA);
    do_read("read10", 16'd10);
    en = 1'b0; we = 1'b1; addr = 16'd10; di = 32'h1234;
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("en_low_hold", dout, 32'hA);
    end
    we = 1'b0;
    do_read("read10_after_en_low", 16'd10);
    chk("read10_value", dout, 32'hA);

    // Address boundaries, no aliasing.
    do_write(16'hFFFF, 32'hFFFFFFFF);
    do_write(16'h0000, 32'h00000001);
    do_read("bound_ffff", 16'hFFFF);
    chk("bound_ffff_val", dout, 32'hFFFFFFFF);
    do_read("bound_0000", 16'h0000);
    chk("bound_0000_val", dout, 32'h00000001);
    do_read("bound_ffff_again", 16'hFFFF);

    // Reset pulse between a write and its read.
    do_write(16'd7, 32'h77);
    rst_n = 1'b0;
    #2;
    exp_do = '0;
    chk("midstream_reset_do", dout, 32'h0);
    cyc();
    rst_n = 1'b1;
    cyc();
    chk("midstream_post_release", dout, 32'h0);
    do_read("midstream_read7", 16'd7);
    chk("midstream_val7", dout, 32'h77);

    // Randomized traffic over a small hot region plus the full range.
    for (int n = 0; n < 3000; n++) begin
      logic [AW-1:0] a;
      logic          e;
      logic          w;
      a = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 31));
      e = 1'($urandom_range(0, 3) != 0);
      w = 1'($urandom);
      if (e && !w && !wr_ok[a]) w = 1'b1;
      en = e; we = w; addr = a; di = DW'($urandom);
      cyc();
      if (e && w) begin
        model[a] = di;
        wr_ok[a] = 1'b1;
      end else if (e) begin
        exp_do = model[a];
      end
      chk("random", dout, exp_do);
    end
    en = 1'b0; we = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_sram_sp
